// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer driving one external full-adder cell, LSB first.
// Optional saturation on signed overflow: define SERIAL_ADDSUB_SAT_EN.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    output logic             fa_en,
    input  logic             fa_sum,
    input  logic             fa_co
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_sub_q;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_last;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_result_nxt;

    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_acc_nxt = {fa_sum, r_acc[WIDTH-1:1]};
    // Carry into the MSB is the registered carry during the final bit step.
    assign w_ovf     = r_carry ^ fa_co;

`ifdef SERIAL_ADDSUB_SAT_EN
    logic r_sign_a;

    always_comb begin
        w_result_nxt = w_acc_nxt;
        if (w_ovf) begin
            w_result_nxt = r_sign_a ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_result_nxt = w_acc_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        fa_a        = 1'b0;
        fa_b        = 1'b0;
        fa_ci       = 1'b0;
        fa_en       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                fa_en = 1'b1;
                fa_a  = r_a_sh[0];
                fa_b  = r_b_sh[0] ^ r_sub_q;
                fa_ci = r_carry;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_sub_q  <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
            r_sign_a <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh   <= op_a;
                        r_b_sh   <= op_b;
                        r_sub_q  <= sub;
                        r_carry  <= sub;
                        r_cnt    <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
                        r_sign_a <= op_a[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_acc   <= w_acc_nxt;
                    r_carry <= fa_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= w_result_nxt;
                        r_cout   <= fa_co;
                        r_ovf    <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: arithmetic reference model plus directed literal cases.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;
    logic         fa_a, fa_b, fa_ci, fa_en, fa_sum, fa_co;

    int checks = 0;
    int failures = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_ci  (fa_ci),
        .fa_en  (fa_en),
        .fa_sum (fa_sum),
        .fa_co  (fa_co)
    );

    // External full-adder cell.
    assign fa_sum = fa_a ^ fa_b ^ fa_ci;
    assign fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycles remaining in the current operation, plus
    // the operation's full arithmetic outcome computed at acceptance.
    int           m_left = 0;
    bit           armed = 0;
    logic [W-1:0] m_a, m_bb, m_carries;
    logic [W-1:0] m_pr, m_res;
    logic         m_pc, m_po, m_cout, m_ovf;

    always @(posedge clk) begin
        logic [W:0] full;
        logic       sa, sb, sr;
        if (rst) begin
            armed  = 1;
            m_left = 0;
            m_res  = '0;
            m_cout = 0;
            m_ovf  = 0;
        end else if (m_left == 0) begin
            if (start) begin
                m_a       = op_a;
                m_bb      = sub ? ~op_b : op_b;
                full      = {1'b0, op_a} + {1'b0, m_bb} + {{W{1'b0}}, sub};
                m_carries = full[W-1:0] ^ op_a ^ m_bb;
                sa = op_a[W-1];
                sb = op_b[W-1];
                sr = full[W-1];
                m_pc = full[W];
                m_po = (sub ? (sa != sb) : (sa == sb)) && (sr != sa);
                m_pr = full[W-1:0];
`ifdef SERIAL_ADDSUB_SAT_EN
                if (m_po) m_pr = sa ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
                m_left = W + 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) begin
                m_res  = m_pr;
                m_cout = m_pc;
                m_ovf  = m_po;
            end
        end
    end

    always @(negedge clk) begin
        int i;
        if (armed) begin
            i = W + 1 - m_left;
            chk("busy",   busy,   m_left > 0);
            chk("done",   done,   m_left == 1);
            chk("fa_en",  fa_en,  m_left > 1);
            chk("fa_a",   fa_a,   (m_left > 1) ? m_a[i]       : 1'b0);
            chk("fa_b",   fa_b,   (m_left > 1) ? m_bb[i]      : 1'b0);
            chk("fa_ci",  fa_ci,  (m_left > 1) ? m_carries[i] : 1'b0);
            chk("result", result, m_res);
            chk("cout",   cout,   m_cout);
            chk("ovf",    ovf,    m_ovf);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int en = 0;
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1;
        @(negedge clk);
        start = 0;
        op_a = $urandom; op_b = $urandom; sub = $urandom_range(0, 1);
        for (int n = 0; n < 40 && !done; n++) begin
            if (fa_en) en++;
            @(negedge clk);
        end
        chk("lit_done_seen", done, 1'b1);
        chk("lit_result", result, er);
        chk("lit_cout", cout, ec);
        chk("lit_ovf", ovf, eo);
        chk("lit_run_cycles", en, W);
    endtask

    initial begin
        int ndone;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_fa_en", fa_en, 0);
        rst = 0;

        run_op(8'h25, 8'h17, 0, 8'h3C, 0, 0);
        run_op(8'h10, 8'h20, 1, 8'hF0, 0, 0);
        run_op(8'h20, 8'h10, 1, 8'h10, 1, 0);
`ifdef SERIAL_ADDSUB_SAT_EN
        run_op(8'h7F, 8'h01, 0, 8'h7F, 0, 1);
        run_op(8'h80, 8'h01, 1, 8'h80, 1, 1);
`else
        run_op(8'h7F, 8'h01, 0, 8'h80, 0, 1);
        run_op(8'h80, 8'h01, 1, 8'h7F, 1, 1);
`endif
        @(negedge clk);

        // start held high: one operation per W+2 cycles
        ndone = 0;
        start = 1;
        for (int n = 0; n < 40; n++) begin
            op_a = $urandom; op_b = $urandom; sub = $urandom_range(0, 1);
            @(negedge clk);
            if (done) ndone++;
        end
        start = 0;
        chk("held_start_ops", ndone, 4);
        repeat (12) @(negedge clk);

        // reset at the 4th RUN edge
        op_a = 8'h11; op_b = 8'h22; sub = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_fa", {fa_a, fa_b, fa_ci, fa_en}, 0);
        run_op(8'hFF, 8'h01, 0, 8'h00, 1, 0);

        // reset together with start: stays idle
        @(negedge clk);
        rst = 1; start = 1;
        @(negedge clk);
        rst = 0; start = 0;
        @(negedge clk);
        chk("rst_start_busy", busy, 0);

        // randomized traffic, including start pulses while busy and sparse resets
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            sub   = $urandom_range(0, 1);
            op_a  = $urandom;
            op_b  = $urandom;
            if ($urandom_range(0, 3) == 0) op_a = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h80;
            rst   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 0; start = 0;
        repeat (W + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
